// File: rtl/fetch_queue.sv
// Instruction fetch unit with a first-word fall-through instruction queue.
// Requests one word per cycle while there is room; redirects flush the queue and reload the fetch PC.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic [XLEN-1:0]            iInitialPC,
    input  logic                       iRedirect,
    input  logic [XLEN-1:0]            iRedirectPC,
    output logic                       IwReadEnable,
    output logic [XLEN-1:0]            IwAddress,
    input  logic                       IwReadValid,
    input  logic [31:0]                IwReadData,
    output logic                       oInstrValid,
    output logic [31:0]                oInstr,
    output logic [XLEN-1:0]            oInstrPC,
    input  logic                       iInstrReady,
    output logic [$clog2(DEPTH+1)-1:0] oCount,
    output logic                       oFull,
    output logic                       oMisalign
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            misalign_q, misalign_d;

    logic [31:0]     instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];

    logic full_s;
    logic empty_s;
    logic req_s;
    logic push_s;
    logic pop_s;

    // Queue status and handshake qualification
    always_comb begin
        full_s  = (count_q == CW'(DEPTH));
        empty_s = (count_q == {CW{1'b0}});
        req_s   = !full_s && !iRedirect && !misalign_q && !iRST;
        push_s  = req_s && IwReadValid;
        pop_s   = !empty_s && iInstrReady && !iRST;
    end

    // Next-state: a redirect overrides any push or pop in the same cycle
    always_comb begin
        fpc_d      = fpc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        misalign_d = misalign_q;
        if (iRedirect) begin
            fpc_d      = iRedirectPC;
            head_d     = {AW{1'b0}};
            tail_d     = {AW{1'b0}};
            count_d    = {CW{1'b0}};
            misalign_d = |iRedirectPC[1:0];
        end else begin
            if (push_s) begin
                tail_d = tail_q + AW'(1'b1);
                fpc_d  = fpc_q + XLEN'(3'd4);
            end else begin
                tail_d = tail_q;
                fpc_d  = fpc_q;
            end
            if (pop_s) begin
                head_d = head_q + AW'(1'b1);
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1'b1);
                2'b01:   count_d = count_q - CW'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            fpc_q      <= iInitialPC;
            head_q     <= {AW{1'b0}};
            tail_q     <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            misalign_q <= 1'b0;
        end else begin
            fpc_q      <= fpc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Queue storage; contents are never cleared, readers are gated by valid
    always_ff @(posedge iCLK) begin
        if (push_s) begin
            instr_mem_q[tail_q] <= IwReadData;
            pc_mem_q[tail_q]    <= fpc_q;
        end
    end

    // Bus request and first-word fall-through head outputs
    always_comb begin
        IwReadEnable = req_s;
        IwAddress    = fpc_q;
        oInstrValid  = !empty_s && !iRST;
        oCount       = count_q;
        oFull        = full_s && !iRST;
        oMisalign    = misalign_q;
        if (oInstrValid) begin
            oInstr   = instr_mem_q[head_q];
            oInstrPC = pc_mem_q[head_q];
        end else begin
            oInstr   = 32'h0000_0000;
            oInstrPC = {XLEN{1'b0}};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand sequences and
// randomized traffic compared against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam logic [31:0] KEY = 32'hA5A5_0F0F;

    logic              iCLK = 1'b0;
    logic              iRST = 1'b1;
    logic [XLEN-1:0]   iInitialPC = 32'h0040_0000;
    logic              iRedirect = 1'b0;
    logic [XLEN-1:0]   iRedirectPC = 32'h0;
    logic              IwReadEnable;
    logic [XLEN-1:0]   IwAddress;
    logic              IwReadValid = 1'b0;
    logic [31:0]       IwReadData = 32'h0;
    logic              oInstrValid;
    logic [31:0]       oInstr;
    logic [XLEN-1:0]   oInstrPC;
    logic              iInstrReady = 1'b0;
    logic [2:0]        oCount;
    logic              oFull;
    logic              oMisalign;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .iCLK(iCLK), .iRST(iRST), .iInitialPC(iInitialPC),
        .iRedirect(iRedirect), .iRedirectPC(iRedirectPC),
        .IwReadEnable(IwReadEnable), .IwAddress(IwAddress),
        .IwReadValid(IwReadValid), .IwReadData(IwReadData),
        .oInstrValid(oInstrValid), .oInstr(oInstr), .oInstrPC(oInstrPC),
        .iInstrReady(iInstrReady), .oCount(oCount), .oFull(oFull),
        .oMisalign(oMisalign)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, redir;
        logic [31:0] rpc;
        logic        rv, rdy;
        logic        chk_state;
        logic [2:0]  cnt;
        logic        ren, vld, full, mis;
        logic [31:0] addr, hpc;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic redir, input logic [31:0] rpc,
                                input logic rv, input logic rdy, input logic chk,
                                input logic [2:0] cnt, input logic ren, input logic vld,
                                input logic full, input logic mis,
                                input logic [31:0] addr, input logic [31:0] hpc);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.rv = rv; v.rdy = rdy;
        v.chk_state = chk; v.cnt = cnt; v.ren = ren; v.vld = vld; v.full = full;
        v.mis = mis; v.addr = addr; v.hpc = hpc;
        return v;
    endfunction

    // Reference model: queue of fetched {pc, instr} plus fetch PC and sticky flag
    logic [31:0] m_pc[$];
    logic [31:0] m_ins[$];
    logic [31:0] m_fpc;
    logic        m_mis;
    bit          m_known = 0;

    task automatic mstep(input logic rst, input logic redir, input logic [31:0] rpc,
                         input logic rv, input logic rdy);
        logic        e_ren, e_vld;
        logic [31:0] data;
        data = $urandom;
        iRST = rst; iRedirect = redir; iRedirectPC = rpc;
        IwReadValid = rv; IwReadData = data; iInstrReady = rdy;
        e_ren = !rst && (m_pc.size() < DEPTH) && !redir && !m_mis;
        e_vld = !rst && (m_pc.size() != 0);
        @(negedge iCLK);
        check("ren", 32'(IwReadEnable), 32'(e_ren));
        check("valid", 32'(oInstrValid), 32'(e_vld));
        check("full", 32'(oFull), 32'(!rst && m_pc.size() == DEPTH));
        if (m_known) begin
            check("addr", IwAddress, m_fpc);
            check("count", 32'(oCount), 32'(m_pc.size()));
            check("misalign", 32'(oMisalign), 32'(m_mis));
            check("head_pc", oInstrPC, e_vld ? m_pc[0] : 32'h0);
            check("head_instr", oInstr, e_vld ? m_ins[0] : 32'h0);
        end
        @(posedge iCLK);
        if (rst) begin
            m_pc.delete(); m_ins.delete();
            m_fpc = iInitialPC; m_mis = 1'b0; m_known = 1;
        end else if (redir) begin
            m_pc.delete(); m_ins.delete();
            m_fpc = rpc; m_mis = (rpc[1:0] != 2'b00);
        end else begin
            if (e_vld && rdy) begin
                void'(m_pc.pop_front()); void'(m_ins.pop_front());
            end
            if (e_ren && rv) begin
                m_pc.push_back(m_fpc); m_ins.push_back(data);
                m_fpc = m_fpc + 32'd4;
            end
        end
        #1;
    endtask

    vec_t tbl[23];

    initial begin
        // rst redir rpc rv rdy chk cnt ren vld full mis addr hpc
        tbl[0]  = mk(1,0,32'h0,1,0, 0,3'd0,0,0,0,0,32'h0,32'h0);
        tbl[1]  = mk(1,0,32'h0,1,0, 1,3'd0,0,0,0,0,32'h0040_0000,32'h0);
        tbl[2]  = mk(0,0,32'h0,1,0, 1,3'd0,1,0,0,0,32'h0040_0000,32'h0);
        tbl[3]  = mk(0,0,32'h0,1,0, 1,3'd1,1,1,0,0,32'h0040_0004,32'h0040_0000);
        tbl[4]  = mk(0,0,32'h0,1,0, 1,3'd2,1,1,0,0,32'h0040_0008,32'h0040_0000);
        tbl[5]  = mk(0,0,32'h0,1,0, 1,3'd3,1,1,0,0,32'h0040_000C,32'h0040_0000);
        tbl[6]  = mk(0,0,32'h0,1,0, 1,3'd4,0,1,1,0,32'h0040_0010,32'h0040_0000);
        tbl[7]  = mk(0,0,32'h0,1,1, 1,3'd4,0,1,1,0,32'h0040_0010,32'h0040_0000);
        tbl[8]  = mk(0,0,32'h0,1,0, 1,3'd3,1,1,0,0,32'h0040_0010,32'h0040_0004);
        tbl[9]  = mk(0,0,32'h0,1,0, 1,3'd4,0,1,1,0,32'h0040_0014,32'h0040_0004);
        tbl[10] = mk(0,0,32'h0,1,1, 1,3'd4,0,1,1,0,32'h0040_0014,32'h0040_0004);
        tbl[11] = mk(0,1,32'h0040_0100,1,1, 1,3'd3,0,1,0,0,32'h0040_0014,32'h0040_0008);
        tbl[12] = mk(0,0,32'h0,1,1, 1,3'd0,1,0,0,0,32'h0040_0100,32'h0);
        tbl[13] = mk(0,0,32'h0,1,0, 1,3'd1,1,1,0,0,32'h0040_0104,32'h0040_0100);
        tbl[14] = mk(0,1,32'h0040_0102,1,0, 1,3'd2,0,1,0,0,32'h0040_0108,32'h0040_0100);
        tbl[15] = mk(0,0,32'h0,1,0, 1,3'd0,0,0,0,1,32'h0040_0102,32'h0);
        tbl[16] = mk(0,0,32'h0,1,0, 1,3'd0,0,0,0,1,32'h0040_0102,32'h0);
        tbl[17] = mk(0,1,32'h0040_0200,1,0, 1,3'd0,0,0,0,1,32'h0040_0102,32'h0);
        tbl[18] = mk(0,0,32'h0,0,0, 1,3'd0,1,0,0,0,32'h0040_0200,32'h0);
        tbl[19] = mk(0,0,32'h0,0,0, 1,3'd0,1,0,0,0,32'h0040_0200,32'h0);
        tbl[20] = mk(0,0,32'h0,0,0, 1,3'd0,1,0,0,0,32'h0040_0200,32'h0);
        tbl[21] = mk(0,0,32'h0,1,0, 1,3'd0,1,0,0,0,32'h0040_0200,32'h0);
        tbl[22] = mk(0,0,32'h0,0,0, 1,3'd1,1,1,0,0,32'h0040_0204,32'h0040_0200);

        for (int i = 0; i < 23; i++) begin
            iRST = tbl[i].rst; iRedirect = tbl[i].redir; iRedirectPC = tbl[i].rpc;
            IwReadValid = tbl[i].rv; iInstrReady = tbl[i].rdy;
            IwReadData = tbl[i].addr ^ KEY;
            @(negedge iCLK);
            check($sformatf("v%0d_ren", i), 32'(IwReadEnable), 32'(tbl[i].ren));
            check($sformatf("v%0d_valid", i), 32'(oInstrValid), 32'(tbl[i].vld));
            check($sformatf("v%0d_full", i), 32'(oFull), 32'(tbl[i].full));
            if (tbl[i].chk_state) begin
                check($sformatf("v%0d_count", i), 32'(oCount), 32'(tbl[i].cnt));
                check($sformatf("v%0d_mis", i), 32'(oMisalign), 32'(tbl[i].mis));
                check($sformatf("v%0d_addr", i), IwAddress, tbl[i].addr);
                check($sformatf("v%0d_hpc", i), oInstrPC, tbl[i].hpc);
                check($sformatf("v%0d_instr", i), oInstr,
                      tbl[i].vld ? (tbl[i].hpc ^ KEY) : 32'h0);
            end
            @(posedge iCLK);
            #1;
        end

        // Steady state streaming: occupancy constant, head PC advances by 4 each cycle
        iInitialPC = 32'h0000_1000;
        mstep(1, 0, 32'h0, 0, 0);
        mstep(0, 0, 32'h0, 1, 1);
        for (int k = 0; k < 8; k++) begin
            check("stream_count", 32'(oCount), 32'd1);
            check("stream_pc", oInstrPC, 32'h0000_1000 + 32'(4 * k));
            mstep(0, 0, 32'h0, 1, 1);
        end

        // Fetch PC wraps from the top of the address space
        mstep(0, 1, 32'hFFFF_FFFC, 1, 0);
        mstep(0, 0, 32'h0, 1, 0);
        check("wrap_addr", IwAddress, 32'h0000_0000);
        check("wrap_head", oInstrPC, 32'hFFFF_FFFC);
        mstep(0, 0, 32'h0, 1, 0);
        check("wrap_count", 32'(oCount), 32'd2);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic        rst, redir, rv, rdy;
            logic [31:0] rpc;
            rst   = ($urandom_range(0, 299) == 0);
            redir = ($urandom_range(0, 24) == 0);
            rv    = ($urandom_range(0, 9) < 7);
            rdy   = ($urandom_range(0, 9) < 5);
            rpc   = {$urandom, 2'b00} >> 2;
            rpc   = {rpc[29:0], 2'b00};
            if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0;
            if (rst) iInitialPC = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} & 32'hFFFF_FFFC;
            mstep(rst, redir, rpc, rv, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of instruction-queue entries; power of 2, DEPTH >= 2.
REQ-002 SHALL have parameter XLEN, default 32, width of PC and instruction words.
REQ-003 SHALL have port iCLK, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port iRST, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port iInitialPC, input, XLEN: fetch PC loaded at reset.
REQ-006 SHALL have port iRedirect, input, 1: branch/jump/exception redirect, single-cycle pulse.
REQ-007 SHALL have port iRedirectPC, input, XLEN: target PC, sampled when iRedirect=1.
REQ-008 SHALL have port IwReadEnable, output, 1: instruction-bus request.
REQ-009 SHALL have port IwAddress, output, XLEN: instruction-bus address, equal to the fetch PC.
REQ-010 SHALL have port IwReadValid, input, 1: bus acknowledge; IwReadData valid this cycle.
REQ-011 SHALL have port IwReadData, input, 32: fetched instruction word.
REQ-012 SHALL have port oInstrValid, output, 1: queue head valid.
REQ-013 SHALL have port oInstr, output, 32: queue head instruction.
REQ-014 SHALL have port oInstrPC, output, XLEN: PC of queue head.
REQ-015 SHALL have port iInstrReady, input, 1: consumer accepts head this cycle.
REQ-016 SHALL have port oCount, output, $clog2(DEPTH+1): number of occupied entries.
REQ-017 SHALL have port oFull, output, 1: oCount==DEPTH.
REQ-018 SHALL have port oMisalign, output, 1: sticky misaligned-redirect flag.

Function
REQ-019 SHALL hold an internal fetch PC, FPC; IwAddress=FPC at all times.
REQ-020 SHALL drive IwReadEnable=1 iff oCount<DEPTH, iRedirect=0, oMisalign=0 and iRST=0.
REQ-021 A fetch SHALL complete in the cycle where IwReadEnable=1 and IwReadValid=1: {IwReadData, FPC} written at tail, tail++, FPC<=FPC+4 (modulo 2^XLEN).
REQ-022 While IwReadEnable=1 and IwReadValid=0 (wait state), FPC and IwAddress SHALL remain stable; the request holds until acknowledged.
REQ-023 IwReadValid SHALL be ignored when IwReadEnable=0.
REQ-024 Queue SHALL be first-word fall-through: oInstrValid=(oCount!=0); oInstr/oInstrPC combinationally show the head entry, no added latency.
REQ-025 Pop SHALL occur when oInstrValid=1 and iInstrReady=1: head++.
REQ-026 Simultaneous push and pop SHALL leave oCount unchanged; both pointers advance.
REQ-027 Pointers SHALL wrap modulo DEPTH; oCount SHALL never exceed DEPTH or underflow below 0.
REQ-028 Pop with oCount=0 SHALL be ignored; no push occurs while oFull=1 (per REQ-020).
REQ-029 iRedirect=1 SHALL, next edge, set head=tail=0, oCount=0, and FPC<=iRedirectPC; any push or pop that cycle is discarded.
REQ-030 If iRedirectPC[1:0]!=0 on redirect: oMisalign<=1, queue flushed, fetching halts; FPC still loads iRedirectPC.
REQ-031 oMisalign SHALL clear only on a later redirect with aligned target or on reset.
REQ-032 Minimum latency, aligned redirect with zero-wait bus: redirect at cycle N, request at N+1, oInstrValid=1 with oInstrPC=target at N+2.

Reset
REQ-033 On iRST=1 at a rising edge: FPC<=iInitialPC, head=tail=0, oCount=0, oMisalign=0.
REQ-034 During and after reset: oInstrValid=0, oFull=0, IwReadEnable=0 while iRST=1.
REQ-035 Reset SHALL take priority over iRedirect, push and pop; an in-flight request is abandoned.
REQ-036 Queue storage contents need not be cleared; visible outputs SHALL be gated by oInstrValid.

Verification
REQ-037 Reset with iInitialPC=0x00400000, IwReadValid=1, iInstrReady=0 -> IwAddress 0x00400000..0x0040000C fetched over 4 cycles, then oFull=1, IwReadEnable=0, oCount=4, head PC 0x00400000.
REQ-038 Full queue, iInstrReady=1 for 1 cycle -> one pop, oCount=3, then refill next cycle to oCount=4; head PC 0x00400004.
REQ-039 Steady state, IwReadValid=1 and iInstrReady=1 every cycle -> oCount constant, oInstrPC increments by 4 each cycle, no gaps.
REQ-040 IwReadValid held 0 for 3 cycles -> IwAddress stable all 3 cycles; single entry written on the acknowledge cycle.
REQ-041 oCount=3, iRedirect=1 with iRedirectPC=0x00400100 and simultaneous pop+ack -> next cycle oCount=0, FPC=0x00400100; following cycle oInstrPC=0x00400100.
REQ-042 iRedirect with iRedirectPC=0x00400102 -> oMisalign=1, IwReadEnable=0 indefinitely; redirect to 0x00400200 clears oMisalign and resumes fetch; FPC 0xFFFFFFFC fetch wraps to 0x00000000.
